// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mul_pkg;
  localparam int MUL_WIDTH = 16;
  localparam int CNT_W = $clog2(MUL_WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
endpackage

// File: rtl/mul_iter_step.sv
// One combinational shift-and-add iteration built around a controlled adder.
module mul_iter_step #(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplier_next
);
  logic [2*WIDTH-1:0] addend;

  // Controlled adder: the selection bit gates the multiplicand into the sum.
  assign addend      = mplier[0] ? mcand : '0;
  assign acc_next    = acc + addend;
  assign mcand_next  = {mcand[2*WIDTH-2:0], 1'b0};
  assign mplier_next = {1'b0, mplier[WIDTH-1:1]};
endmodule

// File: rtl/mul_seq_controller.sv
// Multi-cycle signed/unsigned multiplier sequencer: magnitude multiply over
// WIDTH shift-and-add iterations, then sign correction and range check.
module mul_seq_controller
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             busy
);
  localparam int PW = 2 * WIDTH;
  localparam int ITER_CNT_W = $clog2(WIDTH);
  localparam logic [ITER_CNT_W-1:0] CNT_LAST = ITER_CNT_W'(WIDTH - 1);
  localparam logic [PW-1:0] HALF = PW'(1) << (WIDTH - 1);

  state_t                state;
  logic [PW-1:0]         acc, mcand, acc_next, mcand_next;
  logic [WIDTH-1:0]      mplier, mplier_next;
  logic [ITER_CNT_W-1:0] cnt;
  logic                  neg, sgn;

  // The most negative input maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic s);
    return (s && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] sign_fix(input logic [PW-1:0] mag,
                                                input logic n);
    logic signed [PW-1:0] p;
    p = n ? -$signed(mag) : $signed(mag);
    return p[WIDTH-1:0];
  endfunction

  // Negative results may reach -2^(WIDTH-1); a zero magnitude never overflows.
  function automatic logic range_check(input logic [PW-1:0] mag,
                                       input logic s, input logic n);
    if (!s)     return |mag[PW-1:WIDTH];
    else if (n) return mag > HALF;
    else        return mag >= HALF;
  endfunction

  mul_iter_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .acc_next   (acc_next),
    .mcand_next (mcand_next),
    .mplier_next(mplier_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      result     <= '0;
      overflow   <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      neg        <= 1'b0;
      sgn        <= 1'b0;
    end else if (flush) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mcand     <= PW'(magnitude(op_a, op_signed));
            mplier    <= magnitude(op_b, op_signed);
            neg       <= op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            sgn       <= op_signed;
            acc       <= '0;
            cnt       <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ITER;
          end
        end
        ITER: begin
          acc    <= acc_next;
          mcand  <= mcand_next;
          mplier <= mplier_next;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= FIX;
        end
        FIX: begin
          result     <= sign_fix(acc, neg);
          overflow   <= range_check(acc, sgn, neg);
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq_controller.sv
// Directed bench for mul_seq_controller with a cycle-level behavioural model.
module tb_mul_seq_controller;
  localparam int W = 16;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst, flush, req_valid, op_signed, resp_ready;
  logic [W-1:0] op_a, op_b;
  logic         req_ready, resp_valid, overflow, busy;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en = 1'b0;

  // Model state: 0 = idle, 1 = computing, 2 = holding a response.
  int           m_mode = 0;
  int           m_left = 0;
  logic [W-1:0] m_res = '0, m_pend_res = '0;
  logic         m_ovf = 1'b0, m_pend_ovf = 1'b0;

  mul_seq_controller #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op_signed (op_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .result    (result),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // True mathematical product, then truncation and range test.
  function automatic void product(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s, output logic [W-1:0] r,
                                  output logic o);
    longint pa, pb, p;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    p  = pa * pb;
    r  = p[W-1:0];
    o  = s ? (p < -32768 || p > 32767) : (p > 65535);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0;
      m_res  <= '0;
      m_ovf  <= 1'b0;
    end else if (flush) begin
      m_mode <= 0;
    end else if (m_mode == 0) begin
      if (req_valid) begin
        logic [W-1:0] r;
        logic         o;
        product(op_a, op_b, op_signed, r, o);
        m_pend_res <= r;
        m_pend_ovf <= o;
        m_left     <= LAT;
        m_mode     <= 1;
      end
    end else if (m_mode == 1) begin
      if (m_left == 1) begin
        m_mode <= 2;
        m_res  <= m_pend_res;
        m_ovf  <= m_pend_ovf;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (resp_ready) begin
      m_mode <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc.req_ready", req_ready, m_mode == 0);
      check("cyc.busy", busy, m_mode != 0);
      check("cyc.resp_valid", resp_valid, m_mode == 2);
      check("cyc.result", result, m_res);
      check("cyc.overflow", overflow, m_ovf);
    end
  end

  task automatic run_op(input string name, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] er, input logic eo, input int hold);
    int n;
    @(negedge clk);
    check($sformatf("%s.ready_in", name), req_ready, 1);
    req_valid = 1'b1; op_a = a; op_b = b; op_signed = s;
    @(negedge clk);
    req_valid = 1'b0; op_a = ~a; op_b = 16'h5A5A; op_signed = ~s;
    check($sformatf("%s.busy", name), busy, 1);
    n = 0;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s.latency", name), n, LAT);
    check($sformatf("%s.result", name), result, er);
    check($sformatf("%s.overflow", name), overflow, eo);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s.hold_result", name), result, er);
      check($sformatf("%s.hold_ovf", name), overflow, eo);
      check($sformatf("%s.hold_ready", name), req_ready, 0);
      check($sformatf("%s.hold_valid", name), resp_valid, 1);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check($sformatf("%s.valid_drop", name), resp_valid, 0);
    check($sformatf("%s.ready_back", name), req_ready, 1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; op_signed = 1'b0;
    resp_ready = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst.req_ready", req_ready, 1);
    check("rst.resp_valid", resp_valid, 0);
    check("rst.result", result, 0);
    check("rst.overflow", overflow, 0);
    check("rst.busy", busy, 0);
    rst = 1'b0;

    run_op("u_3x5", 16'h0003, 16'h0005, 1'b0, 16'h000F, 1'b0, 0);
    run_op("u_100x100", 16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b1, 0);
    run_op("u_ffffx1", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 0);
    run_op("s_m3x7", 16'hFFFD, 16'h0007, 1'b1, 16'hFFEB, 1'b0, 5);
    run_op("s_8000x1", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b0, 0);
    run_op("s_8000xm1", 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 0);
    run_op("s_0x8000", 16'h0000, 16'h8000, 1'b1, 16'h0000, 1'b0, 0);

    // Flush during the 8th iteration cycle, with a competing request.
    @(negedge clk);
    req_valid = 1'b1; op_a = 16'h0005; op_b = 16'h0005; op_signed = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (7) @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; op_a = 16'h0009; op_b = 16'h0009;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    check("flush.busy", busy, 0);
    check("flush.req_ready", req_ready, 1);
    check("flush.resp_valid", resp_valid, 0);
    check("flush.result_kept", result, 16'h0000);
    repeat (20) @(negedge clk);
    check("flush.no_accept", busy, 0);
    check("flush.no_resp", resp_valid, 0);
    run_op("flush_2x2", 16'h0002, 16'h0002, 1'b0, 16'h0004, 1'b0, 0);

    // Asynchronous reset between edges mid-iteration.
    @(negedge clk);
    req_valid = 1'b1; op_a = 16'h1234; op_b = 16'h0056; op_signed = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst.req_ready", req_ready, 1);
    check("arst.resp_valid", resp_valid, 0);
    check("arst.result", result, 0);
    check("arst.overflow", overflow, 0);
    check("arst.busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("arst_7x9", 16'h0007, 16'h0009, 1'b0, 16'h003F, 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mul_seq_controller.md
Name: mul_seq_controller

Overview:
- Multi-cycle sequencer for the ALU multiply path.
- Accepts one operand pair over a valid/ready handshake, then runs a fixed WIDTH-iteration shift-and-add loop. Each iteration performs one controlled addition of the shifted multiplicand, gated by one multiplier bit.
- Applies sign correction and returns a WIDTH-bit low product plus an overflow flag.
- Replaces the fully unrolled array multiplier where area matters. Also provides the signed variant required by the ALU.

Parameters:
- WIDTH, 16, operand and result width in bits (WIDTH >= 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous cancel of any in-flight operation.
- req_valid  in  1  operand pair present.
- req_ready  out  1  controller can accept (IDLE only).
- op_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled on accept.
- op_a  in  WIDTH  multiplicand; sampled on accept.
- op_b  in  WIDTH  multiplier; sampled on accept.
- resp_valid  out  1  result/overflow valid.
- resp_ready  in  1  consumer takes result.
- result  out  WIDTH  low WIDTH bits of the signed/unsigned product.
- overflow  out  1  true product not representable in WIDTH bits for the selected signedness.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset is asynchronous and active-high.
  - state=IDLE; req_ready=1; resp_valid=0; result=0; overflow=0; busy=0.
  - All internal registers (accumulator, counter) are cleared.
  - Reset mid-operation discards the operation; no response is produced.
- States and transitions:
  - IDLE: req_ready=1. On req_valid&&req_ready at edge t, latch the operands:
    - mcand = |op_a| (2*WIDTH bits, zero-extended); mplier = |op_b|.
    - neg = op_signed & (op_a[MSB]^op_b[MSB]); sgn = op_signed.
    - acc = 0; cnt = 0.
    - Go to ITER.
  - ITER: once per cycle:
    - if mplier[0], acc += mcand;
    - mcand <<= 1; mplier >>= 1; cnt++.
    - After WIDTH iterations (cnt==WIDTH-1 on the transition cycle), go to FIX.
  - FIX:
    - p = neg ? -acc : acc (2*WIDTH-bit two's complement); result = p[WIDTH-1:0].
    - Overflow, unsigned: acc >= 2^WIDTH.
    - Overflow, signed: neg ? acc > 2^(WIDTH-1) : acc >= 2^(WIDTH-1). Zero magnitude is never negative overflow.
    - Go to DONE.
  - DONE: resp_valid=1; result and overflow held stable.
    - On resp_ready, go to IDLE; resp_valid drops the next cycle.
    - req_ready stays 0 throughout DONE; no same-cycle accept.
- Latency: accept at edge t → resp_valid high after edge t+WIDTH+1 (WIDTH ITER cycles + 1 FIX cycle). Latency is fixed and independent of operand values; no early termination.
- Magnitude of the most negative value (e.g. 0x8000) is 2^(WIDTH-1). It fits the WIDTH-bit magnitude register unsigned.
- |x| is computed only when op_signed=1. Unsigned operands are used as is.
- flush (synchronous, highest priority below rst):
  - Next state IDLE; resp_valid=0.
  - result and overflow retain their last values.
  - A req_valid in the same cycle is NOT accepted.
- Back-to-back: the earliest next accept is the cycle after the resp handshake.
- Throughput: one operation per WIDTH+3 cycles at best.
- Inputs are ignored outside IDLE. Operand changes after accept have no effect.
- result and overflow change only on the FIX→DONE transition.

Decomposition:
- Shared package mul_pkg:
  - state enum {IDLE, ITER, FIX, DONE};
  - localparam CNT_W = $clog2(WIDTH);
  - default WIDTH constant shared with the ALU.
- One sub-module, mul_iter_step:
  - Purely combinational single iteration.
  - Inputs: acc, mcand, mplier.
  - Outputs: next acc, next mcand, next mplier.
  - Built from the existing controlled-adder cell, with Selection = mplier[0].
- The FSM, counter, sign logic and handshake registers live in mul_seq_controller.

Test Plan:
- Unsigned 3×5, op_signed=0: accept at edge t → resp_valid after edge t+17; result=0x000F, overflow=0. busy high from t+1 until the handshake.
- Unsigned 0x0100×0x0100 → result=0x0000, overflow=1. 0xFFFF×0x0001 → result=0xFFFF, overflow=0.
- Signed cases:
  - 0xFFFD(-3)×0x0007 → result=0xFFEB(-21), overflow=0.
  - 0x8000×0x0001 → result=0x8000, overflow=0.
  - 0x8000×0xFFFF → result=0x8000, overflow=1.
  - 0x0000×0x8000 → 0x0000, overflow=0.
- Handshake: hold resp_ready=0 for 5 cycles after resp_valid → result/overflow stable, req_ready=0 throughout. Assert resp_ready → req_ready=1 the next cycle. A new request accepted that cycle completes correctly.
- flush at the 8th ITER cycle with req_valid=1 → IDLE next cycle, no resp_valid, request not accepted. A following request 2×2 returns 0x0004.
- rst asserted asynchronously mid-ITER (between edges) → outputs take reset values immediately. After release, 7×9 unsigned returns 0x003F.
